// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side request/acknowledge bundle for the SRAM arbiter
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  logic        ldr_req;
  logic        ldr_we;
  logic [19:0] ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_ack;
  logic [15:0] ldr_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata
  );

  // Requester side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin CPU/loader arbiter and strobe sequencer for a 16-bit async SRAM
module sram_arbiter #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  sram_arbiter_if.slave   req_if,
  output logic            CE,
  output logic            UB,
  output logic            LB,
  output logic            OE,
  output logic            WE,
  output logic [19:0]     ADDR,
  inout  wire  [15:0]     Data,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RD_WAIT,
    S_WR_PULSE,
    S_WR_HOLD,
    S_ACK
  } state_t;

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;        // 1 = loader owns the current transaction
  logic          last_q, last_d;      // 1 = loader was served last
  logic          we_q, we_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   cpu_rdata_q, cpu_rdata_d;
  logic [15:0]   ldr_rdata_q, ldr_rdata_d;
  logic          drive;
  logic          pick_ldr;

  // Loader wins when it is the only requester, or on a tie when the CPU was served last.
  assign pick_ldr = req_if.ldr_req && (!req_if.cpu_req || !last_q);

  // State and datapath registers; reset aborts any transaction without acknowledging it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Next-state, request latching, read capture and SRAM strobe decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    CE          = 1'b1;
    UB          = 1'b1;
    LB          = 1'b1;
    OE          = 1'b1;
    WE          = 1'b1;
    drive       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_if.cpu_req || req_if.ldr_req) begin
          gnt_d   = pick_ldr;
          we_d    = pick_ldr ? req_if.ldr_we    : req_if.cpu_we;
          addr_d  = pick_ldr ? req_if.ldr_addr  : req_if.cpu_addr;
          wdata_d = pick_ldr ? req_if.ldr_wdata : req_if.cpu_wdata;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        CE      = 1'b0;
        UB      = 1'b0;
        LB      = 1'b0;
        OE      = we_q;
        drive   = we_q;
        cnt_d   = '0;
        state_d = we_q ? S_WR_PULSE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        OE = 1'b0;
        if (cnt_q == RD_LAST) begin
          if (gnt_q) ldr_rdata_d = Data;
          else       cpu_rdata_d = Data;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_PULSE: begin
        CE    = 1'b0;
        UB    = 1'b0;
        LB    = 1'b0;
        WE    = 1'b0;
        drive = 1'b1;
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      S_WR_HOLD: begin
        CE      = 1'b0;
        UB      = 1'b0;
        LB      = 1'b0;
        drive   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ADDR = addr_q;
  assign Data = drive ? wdata_q : 16'hzzzz;
  assign busy = (state_q != S_IDLE);

  assign req_if.cpu_ack   = (state_q == S_ACK) && !gnt_q;
  assign req_if.ldr_ack   = (state_q == S_ACK) &&  gnt_q;
  assign req_if.cpu_rdata = cpu_rdata_q;
  assign req_if.ldr_rdata = ldr_rdata_q;

endmodule
